// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encoding, default operand width and an operand magnitude helper.
package seq_mul_pkg;

  parameter int unsigned DefaultWidth = 4;
  parameter int unsigned MaxWidth     = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_mul_state_e;

  // Two's-complement magnitude of the low w bits of v; the most negative value maps to 2^(w-1).
  function automatic logic [MaxWidth-1:0] mag(input logic [MaxWidth-1:0] v,
                                               input int unsigned w);
    logic [MaxWidth:0] mask;
    logic [MaxWidth:0] neg;
    mask = (17'd1 << w) - 17'd1;
    neg  = ((~{1'b0, v}) + 17'd1) & mask;
    if (v[w-1]) begin
      return neg[MaxWidth-1:0];
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Control FSM and step down-counter for the sequential multiplier.
// Issues load on an accepted start, step on every RUN cycle and finish on the last step.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            ack_i,
  output logic            load_o,
  output logic            step_o,
  output logic            finish_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [CntW-1:0] count_o
);

  seq_mul_state_e  state_q, state_d;
  logic [CntW-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_o   = 1'b0;
    step_o   = 1'b0;
    finish_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          load_o  = 1'b1;
          count_d = CntW'(Width);
          state_d = StRun;
        end
      end
      StRun: begin
        step_o  = 1'b1;
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          finish_o = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        // start is deliberately ignored here, even alongside ack
        if (ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o  = (state_q == StRun);
  assign done_o  = (state_q == StDone);
  assign count_o = count_q;

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or two's complement per operation.
// Operates on magnitudes and applies the sign to the final accumulator value.
module seq_array_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               ack_i,
  input  logic               sgn_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic            load, step, finish;
  logic [CntW-1:0] count;

  seq_mul_ctrl #(
    .Width(Width),
    .CntW (CntW)
  ) u_ctrl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .ack_i   (ack_i),
    .load_o  (load),
    .step_o  (step),
    .finish_o(finish),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .count_o (count)
  );

  logic [Width-1:0]   mcand_q, mcand_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] product_q, product_d;

  logic [MaxWidth-1:0] a_mag_full, b_mag_full;
  logic                unused_mag;
  logic [CntW-1:0]     shamt;
  logic [2*Width-1:0]  addend, acc_next;

  assign a_mag_full = mag(MaxWidth'(a_i), Width);
  assign b_mag_full = mag(MaxWidth'(b_i), Width);
  assign unused_mag = ^{a_mag_full, b_mag_full};

  // Partial product weight grows by one bit per step as count falls from Width to 1.
  assign shamt    = CntW'(Width) - count;
  assign addend   = (2 * Width)'(mcand_q) << shamt;
  assign acc_next = acc_q + (mplier_q[0] ? addend : '0);

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    if (load) begin
      mcand_d  = sgn_i ? a_mag_full[Width-1:0] : a_i;
      mplier_d = sgn_i ? b_mag_full[Width-1:0] : b_i;
      neg_d    = sgn_i & (a_i[Width-1] ^ b_i[Width-1]);
      acc_d    = '0;
    end else if (step) begin
      acc_d    = acc_next;
      mplier_d = mplier_q >> 1;
      if (finish) begin
        product_d = neg_q ? -acc_next : acc_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench for seq_array_multiplier at Width=4 and Width=8.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start4, ack4, sgn4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] product4;

  logic        start8, ack8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  seq_array_multiplier #(.Width(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .ack_i(ack4), .sgn_i(sgn4),
    .a_i(a4), .b_i(b4), .busy_o(busy4), .done_o(done4), .product_o(product4)
  );

  seq_array_multiplier #(.Width(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .ack_i(ack8), .sgn_i(sgn8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .product_o(product8)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product of the interpreted operands, truncated to 2*w bits.
  function automatic logic [31:0] ref_mul(input logic s, input int w,
                                          input logic [15:0] a, input logic [15:0] b);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[w-1]) av = av - (64'sd1 <<< w);
    if (s && b[w-1]) bv = bv - (64'sd1 <<< w);
    p = av * bv;
    return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  // Start one op; report product, edges from start to done, and busy cycles seen.
  task automatic op4(input logic s, input logic [3:0] av, input logic [3:0] bv,
                     output logic [7:0] p, output int lat, output int nbusy);
    @(negedge clk);
    sgn4 = s; a4 = av; b4 = bv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!done4 && lat < 40) begin
      if (busy4) nbusy++;
      @(negedge clk);
      lat++;
    end
    p = product4;
  endtask

  task automatic ack_op4();
    ack4 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
  endtask

  task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    sgn8 = s; a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    p = product8;
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
  endtask

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  p4, held;
    logic [15:0] p8;
    int          lat, nbusy;

    vecs[0] = '{1'b0, 4'd15, 4'd15, 8'hE1};
    vecs[1] = '{1'b1, 4'b1000, 4'b1000, 8'h40};
    vecs[2] = '{1'b1, 4'b1101, 4'd5, 8'hF1};
    vecs[3] = '{1'b1, 4'd7, 4'b1000, 8'hC8};
    vecs[4] = '{1'b0, 4'd0, 4'd9, 8'h00};
    vecs[5] = '{1'b1, 4'd0, 4'hF, 8'h00};
    vecs[6] = '{1'b1, 4'hF, 4'hF, 8'h01};
    vecs[7] = '{1'b0, 4'd3, 4'd5, 8'h0F};

    rst_n = 1'b0;
    start4 = 0; ack4 = 0; sgn4 = 0; a4 = 0; b4 = 0;
    start8 = 0; ack8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy4), 32'd0);
    check("reset_done", 32'(done4), 32'd0);
    check("reset_product", 32'(product4), 32'd0);
    rst_n = 1'b1;

    // Directed table; first entry also checks busy width, done hold and ack behaviour.
    foreach (vecs[i]) begin
      op4(vecs[i].s, vecs[i].a, vecs[i].b, p4, lat, nbusy);
      check($sformatf("vec%0d_product", i), 32'(p4), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      if (i == 0) begin
        check("vec0_busy_cycles", 32'(nbusy), 32'd4);
        repeat (3) @(negedge clk);
        check("vec0_done_held", 32'(done4), 32'd1);
        held = product4;
        ack_op4();
        check("vec0_idle_busy", 32'(busy4), 32'd0);
        check("vec0_idle_done", 32'(done4), 32'd0);
        check("vec0_product_kept", 32'(product4), 32'(held));
      end else begin
        ack_op4();
      end
    end

    // Exhaustive sweep against the reference model.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          op4(s[0], 4'(a), 4'(b), p4, lat, nbusy);
          check($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), 32'(p4),
                ref_mul(s[0], 4, 16'(a), 16'(b)));
          check($sformatf("sweep_lat_s%0d_a%0d_b%0d", s, a, b), 32'(lat), 32'd4);
          ack_op4();
        end
      end
    end

    // Inputs disturbed and start pulsed during RUN must not affect the result.
    @(negedge clk);
    sgn4 = 0; a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk);
    sgn4 = 1; a4 = 4'hF; b4 = 4'h9;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("midrun_latency", 32'(lat), 32'd4);
    check("midrun_product", 32'(product4), 32'd42);
    ack_op4();
    check("midrun_no_second_op", 32'(busy4), 32'd0);

    // ack and start together in DONE: back to IDLE without starting, then a real start.
    op4(1'b0, 4'd2, 4'd3, p4, lat, nbusy);
    check("ackstart_product", 32'(p4), 32'd6);
    ack4 = 1'b1; start4 = 1'b1; a4 = 4'd4; b4 = 4'd4;
    @(negedge clk);
    ack4 = 1'b0; start4 = 1'b0;
    check("ackstart_idle_busy", 32'(busy4), 32'd0);
    check("ackstart_idle_done", 32'(done4), 32'd0);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("ackstart_restart_busy", 32'(busy4), 32'd1);
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ackstart_restart_product", 32'(product4), 32'd16);
    ack_op4();

    // Reset on the second RUN cycle aborts with no done.
    @(negedge clk);
    sgn4 = 0; a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_product", 32'(product4), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done_later", 32'(done4), 32'd0);
    op4(1'b0, 4'd3, 4'd5, p4, lat, nbusy);
    check("abort_after_product", 32'(p4), 32'h0F);
    check("abort_after_latency", 32'(lat), 32'd4);
    ack_op4();

    // Width=8 directed and random checks.
    op8(1'b0, 8'd255, 8'd255, p8, lat);
    check("w8_unsigned_max", 32'(p8), 32'hFE01);
    check("w8_unsigned_latency", 32'(lat), 32'd8);
    op8(1'b1, 8'h80, 8'h01, p8, lat);
    check("w8_signed_min", 32'(p8), 32'hFF80);
    for (int i = 0; i < 40; i++) begin
      logic       rs;
      logic [7:0] ra, rb;
      rs = 1'($urandom_range(1, 0));
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(rs, ra, rb, p8, lat);
      check($sformatf("w8_rand%0d_s%0d_a%0h_b%0h", i, rs, ra, rb), 32'(p8),
            ref_mul(rs, 8, 16'(ra), 16'(rb)));
      check($sformatf("w8_rand%0d_latency", i), 32'(lat), 32'd8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_array_multiplier.md
Name: seq_array_multiplier

Overview:
- Parametrised sequential shift-and-add multiplier. It is the next generation of the team's 4-bit combinational array multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement, selected per operation.
- Uses one adder iterated over WIDTH cycles, with a start/busy/done/ack handshake.
- Sits between the board switch inputs and the 7-segment/LEDR display logic. Display decoding stays outside this block.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.

Ports:
Clock  input  1  system clock; all state changes on the rising edge
Resetn  input  1  synchronous, active-low reset
start  input  1  request a multiplication; sampled only in IDLE
ack  input  1  consumer acknowledges the result; sampled only in DONE
sgn  input  1  1 = operands are two's complement, 0 = unsigned; latched with start
a  input  WIDTH  multiplicand; latched with start
b  input  WIDTH  multiplier; latched with start
busy  output  1  high while state is RUN
done  output  1  high while state is DONE; product is valid
product  output  2*WIDTH  result register; holds its value until the next result is loaded

Behaviour:
- Reset: one clock is the only clock. Resetn is synchronous and active-low.
  - Resetn=0 at a rising edge forces state=IDLE.
  - It also clears busy=0, done=0, product=0, accumulator=0, count=0.
  - It overrides any other input in the same cycle, including mid-RUN.
  - An aborted operation produces no done.
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- IDLE:
  - If start=1 at the edge, capture sgn.
  - Capture the operand magnitudes mcand=|a| and mplier=|b| as WIDTH-bit unsigned values. Magnitudes are taken only if sgn=1; otherwise the raw values are used.
  - Record neg = sgn & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator, set count=WIDTH, go to RUN.
  - The most negative operand (e.g. -8 at WIDTH=4) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. No special case is needed.
- RUN: one step per edge.
  - If mplier[0]=1, acc += mcand << (WIDTH-count).
  - Then mplier >>= 1 and count -= 1.
  - On the step where count goes 1->0:
    - product <= neg ? -acc_next : acc_next (2*WIDTH two's complement).
    - state goes to DONE.
  - start, a, b and sgn are ignored during RUN.
- DONE:
  - done=1, busy=0.
  - On ack=1, go to IDLE. product keeps its value.
  - start is ignored in DONE, including when start and ack are high in the same cycle. A new start needs at least one cycle in IDLE.
- Latency:
  - start sampled at edge k: busy=1 after edge k.
  - busy=0 and done=1 after edge k+WIDTH.
  - This holds for every operand value; there is no early termination.
- Width rules:
  - Unsigned product is at most (2^WIDTH-1)^2, which fits in 2*WIDTH bits.
  - Signed product lies in -2^(2W-2)..2^(2W-2), which fits in 2*WIDTH bits two's complement. No overflow flag is needed.
- Zero operands complete with the same latency and give product=0. neg is irrelevant because -0=0.
- a, b and sgn may change freely after the start edge.

Decomposition:
- Shared package seq_mul_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH;
  - a function for the WIDTH-bit magnitude.
- One sub-module, seq_mul_ctrl: the FSM plus the down-counter. Its outputs are load, step, finish, busy and done.
- The datapath (mcand/mplier/acc registers, adder, sign correction) stays in the top module.

Test Plan:
- WIDTH=4, sgn=0, a=15, b=15, start pulse -> busy high for exactly 4 cycles, then done=1, product=8'hE1 (225). Hold until ack, then back to IDLE with product unchanged.
- WIDTH=4, sgn=1:
  - a=4'b1000 (-8), b=4'b1000 (-8) -> product=8'h40 (64);
  - a=4'b1101 (-3), b=5 -> product=8'hF1 (-15);
  - a=7, b=4'b1000 -> product=8'hC8 (-56).
- Exhaustive WIDTH=4 sweep, both sgn values (512 operations) -> every product matches the reference a*b.
- Latency is always 4 cycles for every operation in the sweep.
- Change a/b/sgn and pulse start during RUN -> result reflects only the originally latched operands. No second operation starts.
- In DONE, assert ack and start together -> IDLE next cycle with no new operation. A start one cycle later begins a new run.
- Resetn=0 on the 2nd RUN cycle -> next edge gives busy=0, done=0, product=0, state IDLE. A following start with a=3, b=5 yields 8'h0F after 4 cycles.
- WIDTH=8: sgn=0, a=255, b=255 -> done after 8 cycles, product=16'hFE01. sgn=1, a=8'h80, b=8'h01 -> product=16'hFF80.
